ocsim_data_sink: RTL and testbench

Simulation-only valid/ready receiver that consumes a stream from a DUT output or a data source. It drives `inReady` under a programmable duty cycle, counts accepted beats, and checks each beat against an expected-content mode. It checks the protocol rules the sender must obey while stalled, and folds all accepted data into a running checksum. Tests control it through tasks and query its counters at end of test.

---
 rtl/ocsim_data_sink_if.sv | 11 +
 rtl/ocsim_data_sink.sv | 158 +++++++++++++++
 tb/tb_ocsim_data_sink.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/ocsim_data_sink_if.sv
// Valid/ready stream bundle between a sender (master) and the data sink (slave).
interface ocsim_data_sink_if #(
  parameter type Type = logic [31:0]
);
  Type  inData;
  logic inValid;
  logic inReady;

  modport master (output inData, output inValid, input inReady);
  modport slave  (input inData, input inValid, output inReady);
endinterface

// File: rtl/ocsim_data_sink.sv
// Stream sink: duty-cycled inReady, beat counting, content/protocol checking
// and a rotate-xor checksum over all accepted beats.
module ocsim_data_sink #(
  parameter type Type = logic [31:0]
) (
  input  logic                        clock,
  input  logic                        reset,
  ocsim_data_sink_if.slave            sink_if,
  input  logic                        running_i,
  input  logic [6:0]                  duty_cycle_i,
  input  logic [1:0]                  data_contents_i,
  input  logic                        clear_counts_i,
  output logic [31:0]                 count_o,
  output logic [31:0]                 error_count_o,
  output logic [31:0]                 stall_count_o,
  output logic [$bits(Type)-1:0]      checksum_o,
  output logic                        held_o
);

  localparam int unsigned W        = $bits(Type);
  localparam int unsigned LfsrW    = 16;
  localparam int unsigned ProdW    = LfsrW + 7;
  localparam logic [1:0]  DtRandom = 2'd0;
  localparam logic [1:0]  DtZero   = 2'd1;
  localparam logic [1:0]  DtOne    = 2'd2;

  typedef enum logic {
    S_IDLE,
    S_HELD
  } state_e;

  state_e             state_q;
  logic [W-1:0]       held_data_q;
  logic [LfsrW-1:0]   lfsr_q;
  logic               in_ready_q;
  logic               illegal_seen_q;
  logic [31:0]        count_q;
  logic [31:0]        error_count_q;
  logic [31:0]        stall_count_q;
  logic [W-1:0]       checksum_q;

  logic [W-1:0]       data_c;
  logic               valid_c;
  logic               xfer_c;
  logic               stall_c;
  logic               content_err_c;
  logic               illegal_hit_c;
  logic               dropped_c;
  logic               changed_c;
  logic [31:0]        err_inc_c;
  logic [ProdW-1:0]   prod_c;
  logic [6:0]         pct_c;

  assign data_c  = sink_if.inData;
  assign valid_c = sink_if.inValid;
  assign xfer_c  = valid_c & in_ready_q;
  assign stall_c = valid_c & ~in_ready_q;

  // Scale the LFSR into 0..99 so duty 0 never and duty >=100 always asserts ready.
  assign prod_c = ProdW'(lfsr_q) * ProdW'(100);
  assign pct_c  = prod_c[ProdW-1:LfsrW];

  // Content check applies only to accepted beats; an illegal mode is reported once.
  always_comb begin
    content_err_c = 1'b0;
    illegal_hit_c = 1'b0;
    if (xfer_c) begin
      case (data_contents_i)
        DtRandom: content_err_c = 1'b0;
        DtZero:   content_err_c = (data_c != '0);
        DtOne:    content_err_c = (data_c != '1);
        default: begin
          illegal_hit_c = 1'b1;
          content_err_c = ~illegal_seen_q;
        end
      endcase
    end
  end

  // Protocol checks against the beat held since the first stalled edge.
  always_comb begin
    dropped_c = 1'b0;
    changed_c = 1'b0;
    if (state_q == S_HELD) begin
      dropped_c = ~valid_c;
      changed_c = valid_c & (data_c != held_data_q);
    end
    err_inc_c = 32'(content_err_c) + 32'(changed_c) + 32'(dropped_c);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      held_data_q    <= '0;
      lfsr_q         <= LfsrW'(16'hACE1);
      in_ready_q     <= 1'b0;
      illegal_seen_q <= 1'b0;
      count_q        <= '0;
      error_count_q  <= '0;
      stall_count_q  <= '0;
      checksum_q     <= '0;
    end else begin
      lfsr_q     <= {1'b0, lfsr_q[LfsrW-1:1]} ^ (lfsr_q[0] ? LfsrW'(16'hB400) : '0);
      in_ready_q <= running_i && (pct_c < duty_cycle_i);

      if (illegal_hit_c) begin
        illegal_seen_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (stall_c) begin
            held_data_q <= data_c;
            state_q     <= S_HELD;
          end
        end
        S_HELD: begin
          if (!valid_c) begin
            state_q <= S_IDLE;
          end else begin
            // Track the new value so a single change is reported once.
            if (changed_c) begin
              held_data_q <= data_c;
            end
            if (in_ready_q) begin
              state_q <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase

      if (clear_counts_i) begin
        count_q       <= '0;
        error_count_q <= '0;
        stall_count_q <= '0;
        checksum_q    <= '0;
      end else begin
        if (xfer_c) begin
          count_q    <= count_q + 32'd1;
          checksum_q <= {checksum_q[W-2:0], checksum_q[W-1]} ^ data_c;
        end
        error_count_q <= error_count_q + err_inc_c;
        if (stall_c) begin
          stall_count_q <= stall_count_q + 32'd1;
        end
      end
    end
  end

  assign sink_if.inReady = in_ready_q;
  assign count_o         = count_q;
  assign error_count_o   = error_count_q;
  assign stall_count_o   = stall_count_q;
  assign checksum_o      = checksum_q;
  assign held_o          = (state_q == S_HELD);

endmodule

// File: tb/tb_ocsim_data_sink.sv
// Scoreboard bench for ocsim_data_sink: sent beats are queued and folded into a
// reference checksum/count as the sink accepts them.
module tb_ocsim_data_sink;

  logic        clock;
  logic        reset;
  logic        running;
  logic [6:0]  duty;
  logic [1:0]  contents;
  logic        clear;
  logic [31:0] count_o;
  logic [31:0] error_count_o;
  logic [31:0] stall_count_o;
  logic [31:0] checksum_o;
  logic        held_o;

  int unsigned n_cmp;
  int unsigned n_err;

  logic [31:0] exp_q[$];
  logic [31:0] m_count;
  logic [31:0] m_sum;

  ocsim_data_sink_if #(.Type(logic [31:0])) sif ();

  ocsim_data_sink #(.Type(logic [31:0])) dut (
    .clock           (clock),
    .reset           (reset),
    .sink_if         (sif.slave),
    .running_i       (running),
    .duty_cycle_i    (duty),
    .data_contents_i (contents),
    .clear_counts_i  (clear),
    .count_o         (count_o),
    .error_count_o   (error_count_o),
    .stall_count_o   (stall_count_o),
    .checksum_o      (checksum_o),
    .held_o          (held_o)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Each accepted beat is popped and folded into the reference model.
  always @(posedge clock) begin
    if (!reset && sif.inValid && sif.inReady) begin
      logic [31:0] d;
      check_eq("beat_expected", 32'(exp_q.size() != 0), 32'd1);
      d = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
      m_count = m_count + 32'd1;
      m_sum   = {m_sum[30:0], m_sum[31]} ^ d;
      #1;
      check_eq("beat_count", count_o, m_count);
      check_eq("beat_checksum", checksum_o, m_sum);
    end
  end

  task automatic send(input logic [31:0] d);
    bit done;
    done = 1'b0;
    @(negedge clock);
    sif.inValid = 1'b1;
    sif.inData  = d;
    exp_q.push_back(d);
    for (int i = 0; i < 200 && !done; i++) begin
      @(posedge clock);
      if (sif.inReady) done = 1'b1;
    end
    check_eq("send_accepted", 32'(done), 32'd1);
  endtask

  task automatic idle();
    @(negedge clock);
    sif.inValid = 1'b0;
  endtask

  task automatic clear_counts();
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    clear   = 1'b0;
    m_count = '0;
    m_sum   = '0;
  endtask

  initial begin
    clock = 1'b0; reset = 1'b1; running = 1'b0; duty = 7'd100; contents = 2'd0;
    clear = 1'b0; sif.inValid = 1'b0; sif.inData = '0;
    m_count = '0; m_sum = '0; n_cmp = 0; n_err = 0;

    // Reset state
    @(negedge clock); @(negedge clock);
    check_eq("rst_ready", 32'(sif.inReady), 32'd0);
    check_eq("rst_count", count_o, 32'd0);
    check_eq("rst_checksum", checksum_o, 32'd0);
    reset = 1'b0;
    @(negedge clock);
    check_eq("stopped_ready", 32'(sif.inReady), 32'd0);

    // Zero contents, back-to-back
    contents = 2'd1;
    running  = 1'b1;
    @(negedge clock);
    check_eq("start_ready", 32'(sif.inReady), 32'd1);
    for (int i = 0; i < 16; i++) send(32'h0);
    idle();
    check_eq("zero_count", count_o, 32'd16);
    check_eq("zero_errors", error_count_o, 32'd0);
    check_eq("zero_stalls", stall_count_o, 32'd0);
    check_eq("zero_checksum", checksum_o, 32'd0);

    // Checksum of a known sequence
    clear_counts();
    contents = 2'd0;
    send(32'h1); send(32'h2); send(32'h4);
    idle();
    check_eq("sum3", checksum_o, 32'h0000_0004);
    send(32'h8000_0000);
    idle();
    check_eq("sum4", checksum_o, 32'h8000_0008);

    // Content mismatch
    clear_counts();
    contents = 2'd2;
    send(32'hFFFF_FFFF); send(32'hFFFF_FFFE); send(32'hFFFF_FFFF);
    idle();
    check_eq("one_count", count_o, 32'd3);
    check_eq("one_errors", error_count_o, 32'd1);

    // Data changes while stalled
    clear_counts();
    contents = 2'd0;
    @(negedge clock); duty = 7'd0;
    @(negedge clock);
    sif.inValid = 1'b1; sif.inData = 32'hA5;
    @(negedge clock);
    sif.inData = 32'h5A; exp_q.push_back(32'h5A);
    @(negedge clock);
    duty = 7'd100;
    @(negedge clock);
    @(posedge clock);
    idle();
    check_eq("bp_stalls", stall_count_o, 32'd3);
    check_eq("bp_errors", error_count_o, 32'd1);
    check_eq("bp_count", count_o, 32'd1);

    // Valid dropped while held
    clear_counts();
    @(negedge clock); duty = 7'd0;
    @(negedge clock);
    sif.inValid = 1'b1; sif.inData = 32'h33;
    @(negedge clock);
    check_eq("drop_held", 32'(held_o), 32'd1);
    sif.inValid = 1'b0;
    @(negedge clock);
    check_eq("drop_errors", error_count_o, 32'd1);
    check_eq("drop_idle", 32'(held_o), 32'd0);
    check_eq("drop_count", count_o, 32'd0);
    duty = 7'd100;

    // Stop mid-stall keeps the beat held
    clear_counts();
    running = 1'b0;
    @(negedge clock);
    sif.inValid = 1'b1; sif.inData = 32'h77; exp_q.push_back(32'h77);
    @(negedge clock); @(negedge clock); @(negedge clock);
    check_eq("stop_held", 32'(held_o), 32'd1);
    check_eq("stop_stalls3", stall_count_o, 32'd3);
    running = 1'b1;
    @(negedge clock);
    @(posedge clock);
    idle();
    check_eq("stop_stalls", stall_count_o, 32'd4);
    check_eq("stop_count", count_o, 32'd1);

    // Illegal content mode reports once
    clear_counts();
    contents = 2'd3;
    send(32'h1); send(32'h2);
    idle();
    check_eq("illegal_errors", error_count_o, 32'd1);
    check_eq("illegal_count", count_o, 32'd2);

    // Partial duty cycle
    clear_counts();
    contents = 2'd0; duty = 7'd50;
    for (int i = 0; i < 20; i++) send($urandom);
    idle();
    check_eq("duty50_count", count_o, 32'd20);
    check_eq("duty50_errors", error_count_o, 32'd0);
    duty = 7'd100;

    // Asynchronous reset mid-stream
    clear_counts();
    for (int i = 0; i < 5; i++) send(32'h100 + 32'(i));
    idle();
    #2 reset = 1'b1;
    #1;
    check_eq("arst_ready", 32'(sif.inReady), 32'd0);
    check_eq("arst_count", count_o, 32'd0);
    check_eq("arst_errors", error_count_o, 32'd0);
    check_eq("arst_checksum", checksum_o, 32'd0);
    m_count = '0; m_sum = '0;
    #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) send(32'h200 + 32'(i));
    idle();
    check_eq("post_rst_count", count_o, 32'd3);

    check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
